rsa_seq_ctrl: RTL
=================

Name: rsa_seq_ctrl

Overview:
- Job sequencer in front of the RSA systolic array.
- Accepts one matrix job command (M, N, K) and drives the RSA init/config phase with generated words.
- Meters exactly M*N X words and K*N Y words from upstream sources into RSA, counts M*K results out to the consumer, then pulses done.
- Sits between the host/DMA streams and RSA's init/Xin/Yin/out val-rdy ports.

Parameters:
- IN_LEN, 8, data width of init/X/Y words (matches RSA IN_LEN).
- OUT_LEN, 8, result word width (matches RSA OUT_LEN).
- DIM_W, 4, width of each job dimension M, N, K.
- CNT_W, 8, word-counter width; must be >= 2*DIM_W.

Ports:
- clk  in  1  single system clock, rising edge.
- sys_rst  in  1  asynchronous, active-low reset.
- cmd_val  in  1  job command valid.
- cmd_rdy  out  1  job command accepted; high only in IDLE.
- cmd_m / cmd_n / cmd_k  in  DIM_W each  job dimensions.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job completion.
- err  out  1  one-cycle pulse when a command with a zero dimension is rejected.
- init_val  out  1  to RSA init_val.
- init_data  out  IN_LEN  to RSA init_data.
- init_rdy  in  1  from RSA.
- xs_val  in  1  upstream X source valid.
- xs_data  in  IN_LEN  upstream X data.
- xs_rdy  out  1  upstream X ready.
- Xin_val  out  1  to RSA.
- Xin_data  out  IN_LEN  to RSA.
- Xin_rdy  in  1  from RSA.
- ys_val / ys_data / ys_rdy  in / in / out  1 / IN_LEN / 1  upstream Y stream, same rules as X.
- Yin_val / Yin_data / Yin_rdy  out / out / in  1 / IN_LEN / 1  RSA Y port.
- out_val  in  1  RSA result valid.
- out_data  in  OUT_LEN  RSA result data.
- out_rdy  out  1  to RSA.
- res_val  out  1  downstream result valid.
- res_data  out  OUT_LEN  downstream result data.
- res_rdy  in  1  downstream ready.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - FSM returns to IDLE from any state, including mid-job.
  - All counters and latched dimensions cleared.
  - busy, done, err, init_val, xs_rdy, ys_rdy, Xin_val, Yin_val, out_rdy, res_val are 0; init_data is 0.
- Handshake rule: a transfer occurs on a rising edge where val && rdy. Data is held stable while val=1 and rdy=0.
- FSM states: IDLE, INIT, STREAM, DRAIN, DONE.
- IDLE:
  - cmd_rdy=1.
  - On cmd_val with all three dimensions nonzero: latch M, N, K; compute and register XT=M*N, YT=K*N, OT=M*K (CNT_W bits, zero-extended); go to INIT.
  - If any dimension is 0: pulse err for 1 cycle and stay in IDLE.
- INIT:
  - init_val=1 from the first cycle after command accept.
  - init_data is a registered word selected by idx 0..3: word0=M, word1=N, word2=K, word3=OT[IN_LEN-1:0]; all zero-extended to IN_LEN.
  - idx advances on each init handshake; after the idx=3 handshake go to STREAM and drop init_val.
- STREAM (X/Y paths are combinational pass-through, zero added latency):
  - Xin_val = xs_val && (xc<XT); xs_rdy = Xin_rdy && (xc<XT); Xin_data = xs_data. xc increments on each Xin handshake.
  - Y path is identical, using yc and YT.
  - Once its count is reached, each channel is closed: val and rdy forced to 0, further source words are not consumed.
  - X and Y progress independently; either may finish first.
- Result path (active in STREAM and DRAIN only, 0 otherwise):
  - res_val = out_val && (oc<OT); out_rdy = res_rdy && (oc<OT); res_data = out_data.
  - oc increments on each result handshake.
- STREAM exits to DRAIN when xc==XT and yc==YT.
- DRAIN: exits to DONE when oc==OT. If oc==OT is reached while still in STREAM, the FSM still passes through DRAIN for one cycle.
- DONE: done=1 for exactly one cycle, busy=1; next state is IDLE, where counters clear.
- Simultaneous events: X, Y and result handshakes in the same cycle are all counted. A final X and final Y handshake in the same cycle moves to DRAIN on the next edge.
- Out-of-phase results: out_val asserted outside STREAM/DRAIN is not acknowledged (out_rdy=0).

Test Plan:
- Basic job: M=8, N=4, K=2 with free-running sources and res_rdy=1 -> init words 8,4,2,16 on four handshakes; exactly 32 X and 8 Y handshakes; 16 results forwarded; done pulses once one cycle after DRAIN completes; busy falls the cycle after.
- Init backpressure: init_rdy toggling 1,0,0,1,... -> init_data holds each word while stalled; all 4 words delivered in order; no word skipped or repeated.
- Over-supply: source offers 40 X words for a 32-word job -> exactly 32 consumed; xs_rdy stays 0 afterward; Y completion still drives the FSM to DRAIN.
- Result backpressure: res_rdy=0 for 10 cycles mid-drain -> out_rdy=0 during the stall; no result lost or duplicated; oc reaches exactly 16.
- Zero dimension: cmd with K=0 -> err pulses for 1 cycle; FSM stays IDLE; init_val never rises; a following valid command runs normally.
- Reset mid-STREAM: assert sys_rst low after 10 X words -> all outputs 0 immediately (asynchronous); after release, cmd_rdy=1 and a new job restarts with counts from 0.

Source files
------------

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: job sequencer that configures the RSA array, meters X/Y words in and results out.
module rsa_seq_ctrl #(
  parameter int IN_LEN  = 8,
  parameter int OUT_LEN = 8,
  parameter int DIM_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  input  logic [DIM_W-1:0]   cmd_m,
  input  logic [DIM_W-1:0]   cmd_n,
  input  logic [DIM_W-1:0]   cmd_k,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               init_val,
  output logic [IN_LEN-1:0]  init_data,
  input  logic               init_rdy,
  input  logic               xs_val,
  input  logic [IN_LEN-1:0]  xs_data,
  output logic               xs_rdy,
  output logic               Xin_val,
  output logic [IN_LEN-1:0]  Xin_data,
  input  logic               Xin_rdy,
  input  logic               ys_val,
  input  logic [IN_LEN-1:0]  ys_data,
  output logic               ys_rdy,
  output logic               Yin_val,
  output logic [IN_LEN-1:0]  Yin_data,
  input  logic               Yin_rdy,
  input  logic               out_val,
  input  logic [OUT_LEN-1:0] out_data,
  output logic               out_rdy,
  output logic               res_val,
  output logic [OUT_LEN-1:0] res_data,
  input  logic               res_rdy
);
  typedef enum logic [2:0] {IDLE, INIT, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] n_q, n_d, k_q, k_d;
  logic [CNT_W-1:0] xt_q, xt_d, yt_q, yt_d, ot_q, ot_d;
  logic [CNT_W-1:0] xc_q, xc_d, yc_q, yc_d, oc_q, oc_d;
  logic [1:0] idx_q, idx_d;
  logic [IN_LEN-1:0] init_data_q, init_data_d;
  logic err_q, err_d;
  logic x_open, y_open, r_open, zero_dim;
  assign x_open    = (state_q == STREAM) && (xc_q < xt_q);
  assign y_open    = (state_q == STREAM) && (yc_q < yt_q);
  assign r_open    = ((state_q == STREAM) || (state_q == DRAIN)) && (oc_q < ot_q);
  assign zero_dim  = (cmd_m == '0) || (cmd_n == '0) || (cmd_k == '0);
  assign cmd_rdy   = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign init_val  = state_q == INIT;
  assign init_data = init_data_q;
  assign Xin_val   = xs_val && x_open;
  assign xs_rdy    = Xin_rdy && x_open;
  assign Xin_data  = xs_data;
  assign Yin_val   = ys_val && y_open;
  assign ys_rdy    = Yin_rdy && y_open;
  assign Yin_data  = ys_data;
  assign res_val   = out_val && r_open;
  assign out_rdy   = res_rdy && r_open;
  assign res_data  = out_data;
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    k_d         = k_q;
    xt_d        = xt_q;
    yt_d        = yt_q;
    ot_d        = ot_q;
    xc_d        = xc_q + CNT_W'(Xin_val && Xin_rdy);
    yc_d        = yc_q + CNT_W'(Yin_val && Yin_rdy);
    oc_d        = oc_q + CNT_W'(res_val && res_rdy);
    idx_d       = idx_q;
    init_data_d = init_data_q;
    err_d       = (state_q == IDLE) && cmd_val && zero_dim;
    case (state_q)
      IDLE: begin
        xc_d  = '0;
        yc_d  = '0;
        oc_d  = '0;
        idx_d = '0;
        if (cmd_val && !zero_dim) begin
          n_d         = cmd_n;
          k_d         = cmd_k;
          xt_d        = CNT_W'(cmd_m) * CNT_W'(cmd_n);
          yt_d        = CNT_W'(cmd_k) * CNT_W'(cmd_n);
          ot_d        = CNT_W'(cmd_m) * CNT_W'(cmd_k);
          init_data_d = IN_LEN'(cmd_m);
          state_d     = INIT;
        end
      end
      INIT: if (init_rdy) begin
        idx_d       = idx_q + 2'd1;
        init_data_d = (idx_q == 2'd0) ? IN_LEN'(n_q) :
                      (idx_q == 2'd1) ? IN_LEN'(k_q) :
                      (idx_q == 2'd2) ? IN_LEN'(ot_q) : '0;
        state_d     = (idx_q == 2'd3) ? STREAM : INIT;
      end
      STREAM: state_d = (xc_q == xt_q && yc_q == yt_q) ? DRAIN : STREAM;
      DRAIN:  state_d = (oc_q == ot_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      k_q         <= '0;
      xt_q        <= '0;
      yt_q        <= '0;
      ot_q        <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      oc_q        <= '0;
      idx_q       <= '0;
      init_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      xt_q        <= xt_d;
      yt_q        <= yt_d;
      ot_q        <= ot_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      oc_q        <= oc_d;
      idx_q       <= idx_d;
      init_data_q <= init_data_d;
      err_q       <= err_d;
    end
  end
endmodule
